// File: rtl/fixedpoint_mult_arbiter.sv
// Round-robin arbiter that shares one fixed-latency pipelined multiplier between N_REQ requesters.
// A tag pipe that tracks the multiplier latency sends each product back to the requester that issued it.
`timescale 1ns/1ps
module fixedpoint_mult_arbiter #(
  parameter int N_REQ    = 4,
  parameter int W        = 48,
  parameter int MULT_LAT = 4,
  parameter int MAX_OUT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               mult_en,
  output logic [W-1:0]       mult_a,
  output logic [W-1:0]       mult_b,
  input  logic [W-1:0]       mult_prod,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [W-1:0]       resp_data,
  output logic               busy
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int CW   = $clog2(MAX_OUT + 1);
  localparam int NSTG = MULT_LAT + 1;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic [IDW-1:0]   grant_id;

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q [N_REQ];
  logic [CW-1:0]    cnt_d [N_REQ];
  logic             mult_en_q, mult_en_d;
  logic [W-1:0]     mult_a_q, mult_a_d;
  logic [W-1:0]     mult_b_q, mult_b_d;
  logic [NSTG-1:0]  tag_valid_q, tag_valid_d;
  logic [IDW-1:0]   tag_id_q [NSTG];
  logic [IDW-1:0]   tag_id_d [NSTG];
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [W-1:0]     resp_data_q, resp_data_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CW'(MAX_OUT));
    end
  end

  // The search starts at rr_ptr; the first eligible requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    grant     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_any && elig[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = IDW'((int'(grant_id) + 1) % N_REQ);
    end

    mult_en_d = grant_any;
    mult_a_d  = mult_a_q;
    mult_b_d  = mult_b_q;
    if (grant_any) begin
      mult_a_d = req_a[int'(grant_id)*W +: W];
      mult_b_d = req_b[int'(grant_id)*W +: W];
    end

    tag_valid_d[0] = grant_any;
    tag_id_d[0]    = grant_id;
    for (int s = 1; s < NSTG; s++) begin
      tag_valid_d[s] = tag_valid_q[s-1];
      tag_id_d[s]    = tag_id_q[s-1];
    end

    // The oldest tag lines up with mult_prod for the op it describes.
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (tag_valid_q[NSTG-1]) begin
      resp_valid_d[tag_id_q[NSTG-1]] = 1'b1;
      resp_data_d                    = mult_prod;
    end

    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && !resp_valid_q[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!grant[i] && resp_valid_q[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      mult_en_q    <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      tag_valid_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      for (int s = 0; s < NSTG; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      mult_en_q    <= mult_en_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      tag_valid_q  <= tag_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      cnt_q        <= cnt_d;
      tag_id_q     <= tag_id_d;
    end
  end

  assign req_ready  = grant;
  assign mult_en    = mult_en_q;
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = mult_en_q | (|tag_valid_q) | (|resp_valid_q);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt_chk
    a_cnt_max : assert property (@(posedge clk) disable iff (rst)
      cnt_q[gi] <= CW'(MAX_OUT));
    a_cnt_underflow : assert property (@(posedge clk) disable iff (rst)
      !(resp_valid_q[gi] && !grant[gi] && (cnt_q[gi] == '0)));
  end

endmodule

// File: tb/tb_fixedpoint_mult_arbiter.sv
// Directed bench for fixedpoint_mult_arbiter with a Q24.24 multiplier model of latency 4.
// The second instance uses MAX_OUT=1 to exercise the single-outstanding limit.
`timescale 1ns/1ps
module tb_fixedpoint_mult_arbiter;

  localparam int N = 4;
  localparam int W = 48;
  localparam int LAT = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid, req_valid1;
  logic [N*W-1:0] req_a, req_b, req_a1, req_b1;
  logic [N-1:0]   req_ready, req_ready1;
  logic           mult_en, mult_en1;
  logic [W-1:0]   mult_a, mult_b, mult_a1, mult_b1;
  logic [W-1:0]   mult_prod, mult_prod1;
  logic [N-1:0]   resp_valid, resp_valid1;
  logic [W-1:0]   resp_data, resp_data1;
  logic           busy, busy1;

  int errors = 0;
  int checks = 0;

  fixedpoint_mult_arbiter #(.N_REQ(N), .W(W), .MULT_LAT(LAT), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b), .mult_prod(mult_prod),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
  );

  fixedpoint_mult_arbiter #(.N_REQ(N), .W(W), .MULT_LAT(LAT), .MAX_OUT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_a(req_a1), .req_b(req_b1), .req_ready(req_ready1),
    .mult_en(mult_en1), .mult_a(mult_a1), .mult_b(mult_b1), .mult_prod(mult_prod1),
    .resp_valid(resp_valid1), .resp_data(resp_data1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] fx(input int v);
    longint t;
    t = longint'(v) <<< 24;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] fxmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    return p[W+23:24];
  endfunction

  // Multiplier models: the product of the operands presented while mult_en is high appears LAT cycles later.
  logic [W-1:0] mp [LAT];
  logic [W-1:0] mp1 [LAT];
  always @(posedge clk) begin
    mp[0]  <= fxmul(mult_a, mult_b);
    mp1[0] <= fxmul(mult_a1, mult_b1);
    for (int s = 1; s < LAT; s++) begin
      mp[s]  <= mp[s-1];
      mp1[s] <= mp1[s-1];
    end
  end
  assign mult_prod  = mp[LAT-1];
  assign mult_prod1 = mp1[LAT-1];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [N-1:0] v);
    req_valid = v;
  endtask

  task automatic setOps(input int i, input int a, input int b);
    req_a[i*W +: W] = fx(a);
    req_b[i*W +: W] = fx(b);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetPulse();
    tick();
    applyStimulus('0);
    req_valid1 = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0;
    req_valid1 = '0; req_a1 = '0; req_b1 = '0;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mult_en", 64'(mult_en), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_mult_a", 64'(mult_a), 64'd0);
    checkOutput("rst_resp_data", 64'(resp_data), 64'd0);
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    tick();
    rst = 1'b0;

    // Single request from requester 0.
    $display("[TB] single request");
    tick(); setOps(0, 2, 3); applyStimulus(4'b0001); #1;
    checkOutput("t1_ready", 64'(req_ready), 64'h1);
    tick(); applyStimulus(4'b0000); #1;
    checkOutput("t1_mult_en", 64'(mult_en), 64'd1);
    checkOutput("t1_mult_a", 64'(mult_a), 64'(fx(2)));
    checkOutput("t1_mult_b", 64'(mult_b), 64'(fx(3)));
    checkOutput("t1_busy", 64'(busy), 64'd1);
    for (int c = 2; c <= 5; c++) begin
      tick(); #1;
      checkOutput("t1_no_resp_early", 64'(resp_valid), 64'd0);
    end
    tick(); #1;
    checkOutput("t1_resp_valid", 64'(resp_valid), 64'h1);
    checkOutput("t1_resp_data", 64'(resp_data), 64'(fx(6)));
    tick(); #1;
    checkOutput("t1_resp_done", 64'(resp_valid), 64'd0);
    checkOutput("t1_idle", 64'(busy), 64'd0);

    // All four requesters held valid: strict rotation, one issue per cycle.
    $display("[TB] full rotation");
    resetPulse();
    for (int i = 0; i < N; i++) setOps(i, i + 1, 2);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) applyStimulus(4'b1111);
      #1;
      checkOutput("t2_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k >= 1) begin
        checkOutput("t2_mult_en", 64'(mult_en), 64'd1);
        checkOutput("t2_mult_a", 64'(mult_a), 64'(fx((k - 1) % 4 + 1)));
      end
      if (k >= 6) begin
        checkOutput("t2_resp_valid", 64'(resp_valid), 64'(4'b0001 << ((k - 6) % 4)));
        checkOutput("t2_resp_data", 64'(resp_data), 64'(fx(2 * ((k - 6) % 4 + 1))));
      end
    end
    tick(); applyStimulus(4'b0000);
    repeat (8) tick();
    #1;
    checkOutput("t2_drained", 64'(busy), 64'd0);

    // Requester 2 alone hits its outstanding limit and waits for a response.
    $display("[TB] outstanding limit");
    resetPulse();
    setOps(2, 3, 4);
    tick(); applyStimulus(4'b0100); #1;
    checkOutput("t3_ready_T", 64'(req_ready), 64'h4);
    tick(); setOps(2, 5, 2); #1;
    checkOutput("t3_ready_T1", 64'(req_ready), 64'h4);
    for (int c = 2; c <= 5; c++) begin
      tick(); #1;
      checkOutput("t3_ready_blocked", 64'(req_ready), 64'd0);
    end
    tick(); #1;
    checkOutput("t3_ready_T6", 64'(req_ready), 64'd0);
    checkOutput("t3_resp0_valid", 64'(resp_valid), 64'h4);
    checkOutput("t3_resp0_data", 64'(resp_data), 64'(fx(12)));
    tick(); #1;
    checkOutput("t3_ready_T7", 64'(req_ready), 64'h4);
    checkOutput("t3_resp1_valid", 64'(resp_valid), 64'h4);
    checkOutput("t3_resp1_data", 64'(resp_data), 64'(fx(10)));
    tick(); applyStimulus(4'b0000);

    // Pointer left at 2 by a grant to requester 1; requesters 0 and 3 then alternate.
    $display("[TB] pointer wrap");
    resetPulse();
    setOps(1, 1, 1); setOps(0, 3, 1); setOps(3, 5, 1);
    tick(); applyStimulus(4'b0010); #1;
    checkOutput("t4_ready_1", 64'(req_ready), 64'h2);
    tick(); applyStimulus(4'b1001); #1;
    checkOutput("t4_ready_3a", 64'(req_ready), 64'h8);
    tick(); #1;
    checkOutput("t4_ready_0", 64'(req_ready), 64'h1);
    tick(); #1;
    checkOutput("t4_ready_3b", 64'(req_ready), 64'h8);

    // Asynchronous reset in mid-cycle while several ops are in flight.
    $display("[TB] reset with ops in flight");
    tick(); applyStimulus(4'b0000); #1;
    checkOutput("t5_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_mult_en", 64'(mult_en), 64'd0);
    checkOutput("t5_mult_a", 64'(mult_a), 64'd0);
    checkOutput("t5_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("t5_resp_data", 64'(resp_data), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    tick(); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(); #1;
      checkOutput("t5_no_stale_resp", 64'(resp_valid), 64'd0);
    end
    for (int i = 0; i < N; i++) setOps(i, i + 2, 3);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) applyStimulus(4'b1111);
      #1;
      checkOutput("t5_regrant", 64'(req_ready), 64'(4'b0001 << k));
    end
    tick(); applyStimulus(4'b0000);

    // MAX_OUT=1 instance: requester 1 blocked until its response has been delivered.
    $display("[TB] single outstanding");
    resetPulse();
    req_a1[1*W +: W] = fx(3);
    req_b1[1*W +: W] = fx(3);
    tick(); req_valid1 = 4'b0010; #1;
    checkOutput("t6_ready_T", 64'(req_ready1), 64'h2);
    for (int c = 1; c <= 5; c++) begin
      tick(); #1;
      checkOutput("t6_ready_blocked", 64'(req_ready1), 64'd0);
    end
    tick(); #1;
    checkOutput("t6_ready_R", 64'(req_ready1), 64'd0);
    checkOutput("t6_resp_valid", 64'(resp_valid1), 64'h2);
    checkOutput("t6_resp_data", 64'(resp_data1), 64'(fx(9)));
    tick(); #1;
    checkOutput("t6_ready_R1", 64'(req_ready1), 64'h2);
    tick(); req_valid1 = 4'b0000;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
